// File: rtl/sequence_player.sv
// Plays a stored Simon colour pattern on four LEDs, pacing each step with the
// external delay timer (variable_pulse = on-time, fast_pulse = gap).
//
// state  | meaning
// IDLE   | dark, timer held in reset, waiting for start
// LOAD   | pattern RAM address presented, colour captured next edge
// ON     | LED lit, waiting for variable_pulse
// GAP    | LEDs dark, waiting for fast_pulse
// FINISH | one-cycle done pulse, then back to IDLE
module sequence_player #(
   parameter int MAX_LEN = 32,
   parameter int AW      = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW:0]   seq_len,
   input  logic [3:0]    level,
   output logic [AW-1:0] mem_addr,
   input  logic [1:0]    mem_data,
   output logic          delay_reset,
   output logic [3:0]    variable_pulse_index,
   input  logic          variable_pulse,
   input  logic          fast_pulse,
   output logic [3:0]    led,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ON,
      S_GAP,
      S_FINISH
   } state_t;

   localparam logic [AW:0] MAX_LEN_W = (AW+1)'(MAX_LEN);
   localparam logic [AW:0] ONE_W     = (AW+1)'(1);

   state_t        state_q, state_d;
   logic [AW:0]   idx_q, idx_d;
   logic [AW:0]   len_q, len_d;
   logic [3:0]    lvl_q, lvl_d;
   logic [3:0]    led_q, led_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          dr_q, dr_d;
   logic [AW:0]   idx_next;
   logic          last_step;

   assign idx_next  = idx_q + ONE_W;
   assign last_step = (idx_q == (len_q - ONE_W));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      lvl_d   = lvl_q;
      led_d   = led_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dr_d    = dr_q;

      case (state_q)
         S_IDLE: begin
            led_d  = 4'b0000;
            dr_d   = 1'b1;
            busy_d = 1'b0;
            if (start && !abort) begin
               len_d   = (seq_len > MAX_LEN_W) ? MAX_LEN_W : seq_len;
               lvl_d   = level;
               idx_d   = '0;
               addr_d  = '0;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            dr_d = 1'b1;
            // a zero-length request still shows one busy cycle before done
            if (len_q == '0) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               led_d   = 4'b0001 << mem_data;
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (dr_q) begin
               dr_d = 1'b0;
            end else if (variable_pulse) begin
               led_d   = 4'b0000;
               dr_d    = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (dr_q) begin
               dr_d = 1'b0;
            end else if (fast_pulse) begin
               dr_d = 1'b1;
               if (last_step) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_next;
                  addr_d  = idx_next[AW-1:0];
                  state_d = S_LOAD;
               end
            end
         end
         S_FINISH: begin
            dr_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         led_d   = 4'b0000;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         dr_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         lvl_q   <= '0;
         led_q   <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dr_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         lvl_q   <= lvl_d;
         led_q   <= led_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dr_q    <= dr_d;
      end
   end

   assign mem_addr             = addr_q;
   assign delay_reset          = dr_q;
   assign variable_pulse_index = lvl_q;
   assign led                  = led_q;
   assign busy                 = busy_q;
   assign done                 = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: vector table of whole playbacks plus hand-built
// abort / reset / busy-start / pulse-gating sequences, LED flashes scoreboarded.
module tb_sequence_player;

   localparam int MAX_LEN = 32;
   localparam int AW      = 5;
   localparam int ON_T    = 10;
   localparam int GAP_T   = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW:0]   seq_len = '0;
   logic [3:0]    level = '0;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_data;
   logic          delay_reset;
   logic [3:0]    variable_pulse_index;
   logic          variable_pulse;
   logic          fast_pulse;
   logic [3:0]    led;
   logic          busy;
   logic          done;

   logic [1:0]    mem [MAX_LEN];
   logic [4:0]    tmr_cnt;
   logic          vp_force = 1'b0;
   logic          fp_force = 1'b0;

   sequence_player #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .start                (start),
      .abort                (abort),
      .seq_len              (seq_len),
      .level                (level),
      .mem_addr             (mem_addr),
      .mem_data             (mem_data),
      .delay_reset          (delay_reset),
      .variable_pulse_index (variable_pulse_index),
      .variable_pulse       (variable_pulse),
      .fast_pulse           (fast_pulse),
      .led                  (led),
      .busy                 (busy),
      .done                 (done)
   );

   always #5 clk = ~clk;

   assign mem_data = mem[mem_addr];

   // delay timer model: counts while not held, fires both pulses regardless of
   // which one the player is currently waiting for
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)          tmr_cnt <= '0;
      else if (delay_reset)  tmr_cnt <= '0;
      else if (tmr_cnt != 5'd31) tmr_cnt <= tmr_cnt + 5'd1;
   end
   assign variable_pulse = (tmr_cnt == 5'(ON_T))  | vp_force;
   assign fast_pulse     = (tmr_cnt == 5'(GAP_T)) | fp_force;

   typedef struct {
      logic [3:0]    led;
      logic [AW-1:0] addr;
   } flash_t;

   typedef struct {
      int len;
      int lvl;
      int pat;
      int exp_flash;
   } vec_t;

   flash_t sb[$];
   flash_t mon_e;
   int     n_cmp = 0;
   int     n_err = 0;
   int     flashes = 0;
   int     dones = 0;
   logic [3:0] prev_led = '0;
   logic       prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (led != 4'b0000 && prev_led == 4'b0000) begin
            flashes++;
            if (sb.size() == 0) begin
               check("unexpected_flash", {28'd0, led}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("flash_led", {28'd0, led}, {28'd0, mon_e.led});
               check("flash_addr", {27'd0, mem_addr}, {27'd0, mon_e.addr});
            end
         end
         if (done) begin
            dones++;
            check("done_width", {31'd0, prev_done}, 32'd0);
         end
      end
      prev_led  = led;
      prev_done = done;
   end

   task automatic fill(input int pat);
      for (int i = 0; i < MAX_LEN; i++) begin
         case (pat)
            0:       mem[i] = (i % 3 == 0) ? 2'd0 : ((i % 3 == 1) ? 2'd2 : 2'd1);
            1:       mem[i] = 2'(i % 4);
            default: mem[i] = 2'($urandom_range(3, 0));
         endcase
      end
   endtask

   task automatic push_exp(input int n);
      flash_t e;
      for (int i = 0; i < n; i++) begin
         e.led  = 4'b0001 << mem[i];
         e.addr = AW'(i);
         sb.push_back(e);
      end
   endtask

   task automatic pulse_start(input int len, input int lvl);
      start   = 1'b1;
      seq_len = (AW+1)'(len);
      level   = 4'(lvl);
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int k = 0; k < limit; k++) begin
         if (done) break;
         @(negedge clk);
      end
      check("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_led(input logic lit, input int limit);
      for (int k = 0; k < limit; k++) begin
         if ((led != 4'b0000) == lit) break;
         @(negedge clk);
      end
      check("led_wait", {31'd0, (led != 4'b0000)}, {31'd0, lit});
   endtask

   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, d0;

      vecs[0] = '{len: 3,  lvl: 5,  pat: 0, exp_flash: 3};
      vecs[1] = '{len: 1,  lvl: 2,  pat: 1, exp_flash: 1};
      vecs[2] = '{len: 0,  lvl: 7,  pat: 1, exp_flash: 0};
      vecs[3] = '{len: 40, lvl: 9,  pat: 1, exp_flash: 32};
      vecs[4] = '{len: 32, lvl: 15, pat: 2, exp_flash: 32};
      vecs[5] = '{len: 6,  lvl: 0,  pat: 2, exp_flash: 6};

      fill(1);
      repeat (3) @(negedge clk);
      check("rst_led",   {28'd0, led}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_dreset",{31'd0, delay_reset}, 32'd1);
      check("rst_addr",  {27'd0, mem_addr}, 32'd0);
      check("rst_vpi",   {28'd0, variable_pulse_index}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[v]) begin
         fill(vecs[v].pat);
         f0 = flashes;
         d0 = dones;
         push_exp(vecs[v].exp_flash);
         pulse_start(vecs[v].len, vecs[v].lvl);
         check("busy_after_start", {31'd0, busy}, 32'd1);
         check("done_after_start", {31'd0, done}, 32'd0);
         check("vpi_latched", {28'd0, variable_pulse_index}, 32'(vecs[v].lvl));
         @(negedge clk);
         if (vecs[v].exp_flash == 0) begin
            check("zero_len_done", {31'd0, done}, 32'd1);
            check("zero_len_busy", {31'd0, busy}, 32'd0);
            check("zero_len_led",  {28'd0, led}, 32'd0);
         end else begin
            check("led_latency", {28'd0, led}, {28'd0, 4'b0001 << mem[0]});
            wait_done(2000);
            check("busy_at_done", {31'd0, busy}, 32'd0);
         end
         @(negedge clk);
         check("done_dropped", {31'd0, done}, 32'd0);
         check("flash_count", 32'(flashes - f0), 32'(vecs[v].exp_flash));
         check("done_count", 32'(dones - d0), 32'd1);
         check("sb_empty", 32'(sb.size()), 32'd0);
         check("idle_dreset", {31'd0, delay_reset}, 32'd1);
         repeat (2) @(negedge clk);
      end

      // start while busy: level and length must not change
      fill(1);
      f0 = flashes;
      d0 = dones;
      push_exp(2);
      pulse_start(2, 5);
      wait_led(1'b1, 50);
      pulse_start(7, 9);
      check("busy_start_vpi", {28'd0, variable_pulse_index}, 32'd5);
      wait_done(2000);
      @(negedge clk);
      check("busy_start_flashes", 32'(flashes - f0), 32'd2);
      check("busy_start_dones", 32'(dones - d0), 32'd1);
      repeat (2) @(negedge clk);

      // abort in the second ON of a four-step sequence
      fill(1);
      f0 = flashes;
      d0 = dones;
      push_exp(4);
      pulse_start(4, 3);
      wait_led(1'b1, 50);
      wait_led(1'b0, 50);
      wait_led(1'b1, 50);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_led",  {28'd0, led}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      sb.delete();
      repeat (60) @(negedge clk);
      check("abort_no_done", 32'(dones - d0), 32'd0);
      check("abort_flashes", 32'(flashes - f0), 32'd2);

      // start and abort together in IDLE
      start = 1'b1; abort = 1'b1; seq_len = 6'd3; level = 4'd4;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", {31'd0, busy}, 32'd0);
      repeat (20) @(negedge clk);
      check("start_abort_flashes", 32'(flashes - f0), 32'd2);

      // async reset in the middle of a gap
      fill(0);
      push_exp(3);
      pulse_start(3, 6);
      wait_led(1'b1, 50);
      wait_led(1'b0, 50);
      @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("areset_led",    {28'd0, led}, 32'd0);
      check("areset_busy",   {31'd0, busy}, 32'd0);
      check("areset_dreset", {31'd0, delay_reset}, 32'd1);
      check("areset_vpi",    {28'd0, variable_pulse_index}, 32'd0);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // pulses under delay_reset ignored; both pulses in ON -> only ON's acts
      mem[0] = 2'd3;
      f0 = flashes;
      push_exp(1);
      pulse_start(1, 1);
      wait_led(1'b1, 50);
      vp_force = 1'b1;
      @(negedge clk);
      vp_force = 1'b0;
      check("vp_under_dreset", {28'd0, led}, 32'd8);
      vp_force = 1'b1; fp_force = 1'b1;
      @(negedge clk);
      vp_force = 1'b0; fp_force = 1'b0;
      check("both_pulses_gap_led",  {28'd0, led}, 32'd0);
      check("both_pulses_gap_busy", {31'd0, busy}, 32'd1);
      wait_done(200);
      @(negedge clk);
      check("gate_flashes", 32'(flashes - f0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
